// File: rtl/sipo_frame_ctrl.sv
// ---------------------------------------------------------------------------
// sipo_frame_ctrl
// Serial frame receiver controller. Captures a start / WIDTH data bits
// (LSB first) / optional even parity / stop frame from a bit-strobed serial
// line into a shift stage. Each frame is validated, and a good word is handed
// to a single-entry valid/ready output buffer.
//
// Parameters:
//   WIDTH      data bits per frame (2..16)
//   PARITY_EN  1 = one even-parity bit follows the data bits
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   serial_in_i    serial line, idles at 1
//   bit_en_i       bit strobe; serial_in_i is sampled only when high
//   data_out_o     last accepted word
//   data_valid_o   data_out_o holds an unconsumed word
//   data_ready_i   consumer takes the word on an edge where data_valid_o=1
//   busy_o         receiver is inside a frame
//   parity_err_o   one-cycle pulse: frame dropped for bad parity
//   frame_err_o    one-cycle pulse: frame dropped for bad stop bit
//   overrun_o      one-cycle pulse: good frame dropped, buffer full
// ---------------------------------------------------------------------------
module sipo_frame_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in_i,
    input  logic             bit_en_i,
    output logic [WIDTH-1:0] data_out_o,
    output logic             data_valid_o,
    input  logic             data_ready_i,
    output logic             busy_o,
    output logic             parity_err_o,
    output logic             frame_err_o,
    output logic             overrun_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             perr_q, perr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             pe_q, pe_d;
    logic             fe_q, fe_d;
    logic             ov_q, ov_d;
    logic             stop_edge_s;
    logic             good_s;

    // XOR-reduction of the data word; even parity holds when this matches the parity bit
    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            perr_q  <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    // Next-state logic; every transition is gated by the bit strobe
    always_comb begin
        state_d = state_q;
        if (bit_en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (!serial_in_i) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Datapath, output buffer and error pulse next values
    always_comb begin
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        perr_d      = perr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        pe_d        = 1'b0;
        fe_d        = 1'b0;
        ov_d        = 1'b0;
        busy_d      = (state_d != S_IDLE);
        stop_edge_s = bit_en_i && (state_q == S_STOP);
        // A stop bit of 0 outranks a parity failure
        good_s      = stop_edge_s && serial_in_i && !perr_q;

        if (bit_en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (!serial_in_i) begin
                        cnt_d  = {CW{1'b0}};
                        perr_d = 1'b0;
                    end else begin
                        cnt_d  = cnt_q;
                    end
                end
                S_DATA: begin
                    shreg_d = {serial_in_i, shreg_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                end
                S_PARITY: perr_d = parity_of(shreg_q) ^ serial_in_i;
                S_STOP: begin
                    if (!serial_in_i) begin
                        fe_d = 1'b1;
                    end else if (perr_q) begin
                        pe_d = 1'b1;
                    end else begin
                        fe_d = 1'b0;
                    end
                end
                default: shreg_d = shreg_q;
            endcase
        end else begin
            shreg_d = shreg_q;
        end

        // Buffer: a good word loads when empty or draining on this edge
        if (good_s) begin
            if (!valid_q || data_ready_i) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (valid_q && data_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    assign data_out_o   = data_q;
    assign data_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign parity_err_o = pe_q;
    assign frame_err_o  = fe_q;
    assign overrun_o    = ov_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
module tb_sipo_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b1;
    logic       en4 = 1'b0, en8 = 1'b0, rdy4 = 1'b0, rdy8 = 1'b0;
    logic [3:0] do4;
    logic [7:0] do8;
    logic       dv4, dv8, busy4, busy8, pe4, pe8, fe4, fe8, ov4, ov8;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference buffer model, index 0 = WIDTH4/parity DUT, 1 = WIDTH8/no-parity DUT
    bit          ev[2];
    logic [15:0] ed[2];

    always #5 clk = ~clk;

    sipo_frame_ctrl #(.WIDTH(4), .PARITY_EN(1'b1)) dut4 (
        .clk(clk), .rst(rst), .serial_in_i(serial_in), .bit_en_i(en4),
        .data_out_o(do4), .data_valid_o(dv4), .data_ready_i(rdy4), .busy_o(busy4),
        .parity_err_o(pe4), .frame_err_o(fe4), .overrun_o(ov4)
    );

    sipo_frame_ctrl #(.WIDTH(8), .PARITY_EN(1'b0)) dut8 (
        .clk(clk), .rst(rst), .serial_in_i(serial_in), .bit_en_i(en8),
        .data_out_o(do8), .data_valid_o(dv8), .data_ready_i(rdy8), .busy_o(busy8),
        .parity_err_o(pe8), .frame_err_o(fe8), .overrun_o(ov8)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ctl(input bit sel, input logic en, input logic rdy);
        if (sel) begin
            en8 = en; rdy8 = rdy;
        end else begin
            en4 = en; rdy4 = rdy;
        end
    endtask

    task automatic check_all(input bit sel, input string tag, input bit epe, input bit efe, input bit eov);
        logic [15:0] d;
        d = sel ? {8'h00, do8} : {12'h000, do4};
        chk({tag, ".data"},  d, ed[sel]);
        chk({tag, ".valid"}, {15'd0, (sel ? dv8 : dv4)}, {15'd0, ev[sel]});
        chk({tag, ".perr"},  {15'd0, (sel ? pe8 : pe4)}, {15'd0, epe});
        chk({tag, ".ferr"},  {15'd0, (sel ? fe8 : fe4)}, {15'd0, efe});
        chk({tag, ".ovr"},   {15'd0, (sel ? ov8 : ov4)}, {15'd0, eov});
    endtask

    // Send one complete frame; gaps of gmin..gmax idle (bit_en=0) cycles precede each bit
    task automatic send_frame(input bit sel, input string tag, input logic [15:0] data, input bit pbit,
                              input bit stop, input int gmin, input int gmax, input bit rdy_stop);
        int          n;
        bit          par;
        bit          bits[$];
        int          gap;
        logic [15:0] dm;
        bit          good, epe, efe, eov;
        n   = sel ? 8 : 4;
        par = !sel;
        dm  = data & ((16'd1 << n) - 16'd1);
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) bits.push_back(dm[i]);
        if (par) bits.push_back(pbit);
        bits.push_back(stop);
        for (int k = 0; k < bits.size(); k++) begin
            gap = $urandom_range(gmax, gmin);
            repeat (gap) begin
                @(negedge clk);
                set_ctl(sel, 1'b0, 1'b0);
                serial_in = 1'($urandom);
            end
            @(negedge clk);
            serial_in = bits[k];
            set_ctl(sel, 1'b1, (k == bits.size() - 1) ? rdy_stop : 1'b0);
            @(posedge clk);
            #1;
            if (k == 0) chk({tag, ".busy_start"}, {15'd0, (sel ? busy8 : busy4)}, 16'd1);
        end
        // Expected outcome from the frame rules
        good = stop && (!par || (pbit == ^dm));
        efe  = !stop;
        epe  = stop && par && (pbit != ^dm);
        eov  = good && ev[sel] && !rdy_stop;
        if (good && (!ev[sel] || rdy_stop)) begin
            ed[sel] = dm;
            ev[sel] = 1'b1;
        end else if (!good && ev[sel] && rdy_stop) begin
            ev[sel] = 1'b0;
        end
        check_all(sel, tag, epe, efe, eov);
        chk({tag, ".busy_end"}, {15'd0, (sel ? busy8 : busy4)}, 16'd0);
        @(negedge clk);
        set_ctl(sel, 1'b0, 1'b0);
        serial_in = 1'b1;
        @(posedge clk);
        #1;
        check_all(sel, {tag, ".after"}, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic consume(input bit sel, input string tag);
        @(negedge clk);
        set_ctl(sel, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        ev[sel] = 1'b0;
        check_all(sel, tag, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        set_ctl(sel, 1'b0, 1'b0);
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for a clock
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        ev[0] = 1'b0; ed[0] = 16'd0;
        ev[1] = 1'b0; ed[1] = 16'd0;
        chk({tag, ".busy4"}, {15'd0, busy4}, 16'd0);
        chk({tag, ".busy8"}, {15'd0, busy8}, 16'd0);
        check_all(1'b0, {tag, ".w4"}, 1'b0, 1'b0, 1'b0);
        check_all(1'b1, {tag, ".w8"}, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit          sel;
        logic [15:0] d;
        bit          p, pb, st, rd;
        ev[0] = 1'b0; ed[0] = 16'd0;
        ev[1] = 1'b0; ed[1] = 16'd0;

        // Reset state
        #3;
        check_all(1'b0, "reset.w4", 1'b0, 1'b0, 1'b0);
        check_all(1'b1, "reset.w8", 1'b0, 1'b0, 1'b0);
        chk("reset.busy4", {15'd0, busy4}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Good frame: data 1,1,0,1 -> 4'b1011, parity 1
        send_frame(1'b0, "good", 16'hB, 1'b1, 1'b1, 0, 0, 1'b0);
        chk("good.literal", {12'd0, do4}, 16'h000B);

        // Parity error after a fresh reset
        @(posedge clk);
        async_reset("rst1");
        send_frame(1'b0, "perr", 16'hB, 1'b0, 1'b1, 0, 0, 1'b0);

        // Framing error, then a good frame 0,0,1,0 -> 4'b0100
        send_frame(1'b0, "ferr", 16'hB, 1'b1, 1'b0, 0, 0, 1'b0);
        send_frame(1'b0, "after_ferr", 16'h4, 1'b1, 1'b1, 0, 0, 1'b0);
        chk("after_ferr.literal", {12'd0, do4}, 16'h0004);

        // Overrun, then back-to-back transfer with ready on the stop edge
        consume(1'b0, "drain1");
        send_frame(1'b0, "ovr_first", 16'hB, 1'b1, 1'b1, 0, 0, 1'b0);
        send_frame(1'b0, "ovr", 16'h5, 1'b0, 1'b1, 0, 0, 1'b0);
        chk("ovr.literal", {12'd0, do4}, 16'h000B);
        send_frame(1'b0, "b2b", 16'h5, 1'b0, 1'b1, 0, 0, 1'b1);
        chk("b2b.literal", {12'd0, do4}, 16'h0005);

        // Gapped strobe: bit_en every third cycle
        consume(1'b0, "drain2");
        send_frame(1'b0, "gap3", 16'hB, 1'b1, 1'b1, 2, 2, 1'b0);

        // Mid-frame asynchronous reset after two data bits, then a fresh frame
        @(negedge clk); serial_in = 1'b0; en4 = 1'b1;
        @(negedge clk); serial_in = 1'b1;
        @(negedge clk); serial_in = 1'b0;
        @(posedge clk);
        en4 = 1'b0;
        async_reset("midrst");
        send_frame(1'b0, "fresh", 16'h6, 1'b0, 1'b1, 0, 1, 1'b0);

        // No-parity 8-bit DUT: 0x5A, then consume without a new frame
        send_frame(1'b1, "w8", 16'h5A, 1'b0, 1'b1, 0, 0, 1'b0);
        chk("w8.literal", {8'd0, do8}, 16'h005A);
        consume(1'b1, "w8.drain");

        // Randomized frames on both DUTs against the frame-level model
        for (int i = 0; i < 40; i++) begin
            sel = 1'($urandom);
            d   = 16'($urandom);
            p   = sel ? 1'b0 : ^d[3:0];
            pb  = ($urandom_range(3, 0) == 0) ? ~p : p;
            st  = ($urandom_range(4, 0) != 0);
            rd  = 1'($urandom);
            send_frame(sel, $sformatf("rnd%0d", i), d, pb, st, 0, 3, rd);
            if ($urandom_range(2, 0) == 0) consume(sel, $sformatf("rnd%0d.drain", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
- Serial frame receiver controller. Sequences a WIDTH-bit serial-in/parallel-out shift stage using a start/data/parity/stop frame format.
- Validates each frame and presents the completed word on a valid/ready output buffer.
- Sits between a bit-strobed serial line and a parallel consumer. Replaces free-running shifting with framed, handshaked capture.

Parameters:
- WIDTH, 4, number of data bits per frame; legal range 2..16.
- PARITY_EN, 1, 1 = one even-parity bit follows the data bits; 0 = no parity bit.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- serial_in  input  1  serial line; idle level is 1.
- bit_en  input  1  bit strobe; serial_in is sampled only on clock edges where bit_en=1.
- data_out  output  WIDTH  last accepted word.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts the word on an edge where data_valid=1.
- busy  output  1  state is not IDLE.
- parity_err  output  1  one-cycle pulse when a frame is dropped for bad parity.
- frame_err  output  1  one-cycle pulse when a frame is dropped for a bad stop bit.
- overrun  output  1  one-cycle pulse when a good frame is dropped because the buffer is full.

Behaviour:
- Reset (asynchronous, while rst=1):
  - state=IDLE; internal shift register and bit counter = 0.
  - data_out=0, data_valid=0, busy=0; all error pulses 0.
  - Reset mid-frame aborts the frame with no error pulse.
- Shift rule: on each accepted data bit, shreg <= {serial_in, shreg[WIDTH-1:1]}. The new bit enters the MSB and older bits move toward the LSB, so the first data bit received ends in bit 0 (LSB-first).
- FSM; every transition requires bit_en=1, otherwise the state holds:
  - IDLE: serial_in=0 is the start bit -> DATA, cnt=0. serial_in=1 -> stay in IDLE.
  - DATA: shift, cnt++. When cnt==WIDTH-1, go to PARITY if PARITY_EN=1, else STOP. cnt is clog2(WIDTH) bits wide and is cleared on entry to DATA.
  - PARITY: store perr = (^shreg) ^ serial_in, which must be 0 for even parity over data+parity -> STOP.
  - STOP: always -> IDLE. The result is chosen in priority order:
    - serial_in=0 -> frame_err pulse, word dropped.
    - else perr=1 -> parity_err pulse, word dropped.
    - else the frame is good and goes to the output buffer.
- Output buffer, evaluated on the STOP edge of a good frame:
  - data_valid=0, or data_valid=1 with data_ready=1 on the same edge -> data_out<=shreg, data_valid=1. Back-to-back transfer with no bubble.
  - data_valid=1 with data_ready=0 -> overrun pulse; data_out and data_valid are unchanged and the new word is lost.
- Consumption without a good frame completing: data_valid=1 and data_ready=1 -> data_valid<=0. data_out keeps its old value.
- data_ready while data_valid=0 is ignored.
- Error pulses last exactly one clk cycle, on the cycle following the STOP edge. At most one error pulse fires per frame.
- busy=1 in DATA, PARITY and STOP.
- Latency: data_valid rises on the clk edge that samples the stop bit.
- Bits with bit_en=0 between strobes (arbitrary gaps) do not affect the result.
- A 0 on serial_in right after STOP, on the next bit_en, is a new start bit. There is no idle gap requirement.

Test Plan:
- Reset then good frame, WIDTH=4, PARITY_EN=1, bit_en every cycle, data_ready=0. Line sequence: start 0, data 1,1,0,1 (LSB first), parity 1, stop 1. Required: data_out=4'b1011, data_valid=1, no error pulses, busy falls after the stop bit.
- Parity error: same frame with parity bit 0 -> parity_err pulses once; data_valid stays 0; data_out stays 0.
- Framing error: good data and parity with stop bit 0 -> frame_err pulses once, no parity_err, FSM returns to IDLE. A following good frame with data 0,0,1,0 -> data_out=4'b0100.
- Overrun and back-to-back transfer:
  - With data_valid=1 (data_out=4'b1011) and data_ready=0, a second good frame with data_out target 4'b0101 -> overrun pulse; data_out stays 4'b1011.
  - Repeat with data_ready=1 on the stop edge -> data_out=4'b0101, data_valid stays 1.
- Gapped strobe and mid-frame reset:
  - bit_en asserted every 3rd cycle with serial_in toggling between strobes -> same result as the first scenario.
  - Assert rst asynchronously (between clock edges) after 2 data bits -> busy=0 and data_valid=0 immediately. A fresh frame then decodes correctly.
- PARITY_EN=0, WIDTH=8: frame start 0, data 0x5A sent LSB-first, stop 1 -> data_out=8'h5A. A pre-existing data_valid=1 cleared by data_ready with no new frame -> data_valid=0.
